aud_adc_rx: RTL
===============

# aud_adc_rx

Audio codec ADC serial-port master and receiver for the audio path. It generates the I2S bit clock (`aud_bclk`) and ADC left/right clock (`aud_adclrck`) for the WM8731 codec and deserializes `aud_adcdat` into stereo sample pairs. Pairs are buffered in a small FIFO and handed to the Avalon/DSP side over a valid/ready interface. It is the capture-side counterpart of the DAC serializer on the same codec pins.

## Interface
Parameters:
- `SAMPLE_W`, default 16: bits per channel sample, MSB first.
- `SLOT_W`, default 32: BCLK periods per channel slot. Must satisfy `SLOT_W >= SAMPLE_W+1`.
- `BCLK_HALF`, default 4: `clk` cycles per BCLK half-period. Must be at least 3.
- `FIFO_DEPTH`, default 4: stereo frames buffered. Must be a power of 2.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  reset; one clock; synchronous, active-low.
- `enable`  in  1  run the serial port. Start and stop take effect only at frame boundaries.
- `aud_adcdat`  in  1  codec ADC serial data. Changes on BCLK falling edges.
- `aud_bclk`  out  1  bit clock driven to the codec.
- `aud_adclrck`  out  1  0 = left slot, 1 = right slot.
- `frame_start`  out  1  one-cycle pulse when `bit_cnt` wraps to 0. Used for DAC alignment.
- `sample_left`  out  SAMPLE_W  FIFO head, left channel.
- `sample_right`  out  SAMPLE_W  FIFO head, right channel.
- `sample_valid`  out  1  FIFO non-empty.
- `sample_ready`  in  1  consumer accepts the head frame.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  frames stored.
- `overflow`  out  1  sticky; set when a frame is dropped.
- `clr_overflow`  in  1  clears `overflow`.

## Operation
- State machine has two states:
  - IDLE: `div_cnt` = 0, `aud_bclk` = 0, `bit_cnt` = 0. Moves to RUN when `enable` = 1.
  - RUN: continues running. Moves to IDLE only at a frame wrap (falling edge with `bit_cnt` = 2*SLOT_W-1) while `enable` = 0. No partial frame is ever pushed.
- Divider: `div_cnt` counts 0..BCLK_HALF-1. At BCLK_HALF-1 it wraps and toggles `aud_bclk`. A 0→1 toggle is a rise event; a 1→0 toggle is a fall event.
- `bit_cnt` is 0..2*SLOT_W-1. It increments on each fall event and wraps to 0.
- `aud_adclrck` is `bit_cnt >= SLOT_W`, registered, so it changes together with BCLK falling.
- Slot position `p = bit_cnt mod SLOT_W`. Data format is I2S: one BCLK delay after the LRCK edge.
- `aud_adcdat` passes through a 2-flop synchronizer.
- On a rise event with 1 ≤ p ≤ SAMPLE_W, the synchronized bit shifts into the left or right shift register (left when `bit_cnt` < SLOT_W). Bits with p = 0 or p > SAMPLE_W are ignored.
- On the rise event with `bit_cnt` = SLOT_W+SAMPLE_W, the frame {left, right} is written to the FIFO on the next cycle.
- FIFO is show-ahead. Pop happens when `sample_valid` && `sample_ready`.
- Push while full without a pop in the same cycle: the frame is dropped and `overflow` is set.
- Push and pop in the same cycle while full: both are accepted, `fifo_level` is unchanged, no overflow.
- `clr_overflow` and a drop in the same cycle: `overflow` stays 1.
- Reset mid-frame returns all state to reset values on the next edge: FIFO emptied, shift registers cleared, state IDLE.

## Timing
- Reset values: `aud_bclk` = 0, `aud_adclrck` = 0, `frame_start` = 0, `sample_valid` = 0, `sample_left`/`sample_right` = 0 (head of empty FIFO), `fifo_level` = 0, `overflow` = 0.
- BCLK period is 2*BCLK_HALF clk cycles. Frame length is 2*SLOT_W BCLK periods: 512 clk with defaults, which gives 97.66 kHz.
- With `enable` = 1 and `reset_n` high from cycle 0:
  - First rise event in cycle BCLK_HALF-1, so `aud_bclk` is high from cycle BCLK_HALF.
  - `frame_start` pulses at each wrap, not at start-up.
- Capture sampling: data is stable for ≥ BCLK_HALF cycles before the rise event. The synchronizer adds 2 cycles, which is tolerated because BCLK_HALF ≥ 3.
- Latency, last right-bit rise event to `sample_valid`: 2 cycles (write plus registered flag) when the FIFO is empty.
- `sample_valid` deasserts the cycle after the pop that empties the FIFO. A push in that same cycle keeps it high.

## Test plan
- Stereo capture: codec BFM drives left = 0xA5C3, right = 0x1234 (I2S, changes on BCLK fall), `sample_ready` = 1 → one frame with `sample_left` = 0xA5C3, `sample_right` = 0x1234; `sample_valid` high 2 cycles after the last right bit; LRCK period 512 clk.
- Clock shape: after reset, `aud_bclk` period is 8 clk at 50% duty; `aud_adclrck` toggles only in cycles where `aud_bclk` falls; `aud_adclrck` is high for 32 BCLKs.
- Overflow: `sample_ready` = 0, 5 frames with values 1..5 → `fifo_level` = 4, `overflow` = 1, pops return frames 1..4 in order; `clr_overflow` → `overflow` = 0.
- Full with concurrent pop: FIFO full, `sample_ready` pulsed in the push cycle → no overflow, `fifo_level` stays 4, the new frame is last in order.
- Enable drop mid-frame: deassert `enable` at `bit_cnt` = 10 → frame completes and is pushed; BCLK then holds 0 and LRCK holds 0; re-enable → next frame starts with `frame_start` behaviour intact.
- Reset mid-frame: assert `reset_n` = 0 for 1 cycle during the right slot with 2 frames queued → all outputs at reset values and FIFO empty next cycle; the next full frame captures correctly.

Source files
------------

// File: rtl/aud_adc_rx.sv
// WM8731 ADC port master: drives BCLK/ADCLRCK, deserializes I2S stereo frames into a show-ahead FIFO.
// Frame is visible on sample_valid 2 cycles after its last right bit is sampled; a push to a full FIFO with no pop is dropped and flagged.
module aud_adc_rx #(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 32,
    parameter int BCLK_HALF  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          aud_adcdat,
    output logic                          aud_bclk,
    output logic                          aud_adclrck,
    output logic                          frame_start,
    output logic [SAMPLE_W-1:0]           sample_left,
    output logic [SAMPLE_W-1:0]           sample_right,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int BW = $clog2(2 * SLOT_W);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_W - 1);
    localparam logic [BW-1:0] SLOT     = BW'(SLOT_W);
    localparam logic [BW-1:0] PUSH_BIT = BW'(SLOT_W + SAMPLE_W);
    localparam logic [BW-1:0] P_MAX    = BW'(SAMPLE_W);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                    state_q, state_d;
    logic [DW-1:0]             div_cnt_q, div_cnt_d;
    logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
    logic                      bclk_q, bclk_d;
    logic                      lrck_q, lrck_d;
    logic                      fs_q, fs_d;
    logic                      sync1_q, sync1_d, sync2_q, sync2_d;
    logic [SAMPLE_W-1:0]       left_q, left_d, right_q, right_d;
    logic                      push_q, push_d;
    logic [2*SAMPLE_W-1:0]     mem_q [FIFO_DEPTH];
    logic [2*SAMPLE_W-1:0]     mem_d [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]             level_q, level_d;
    logic                      ovf_q, ovf_d;

    logic                      rise, fall, wrap, in_right;
    logic [BW-1:0]             slot_pos;
    logic                      pop, full, wr_en, drop;
    logic [2*SAMPLE_W-1:0]     head;

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bclk_d    = bclk_q;
        bit_cnt_d = bit_cnt_q;
        rise      = 1'b0;
        fall      = 1'b0;
        // The divider starts in the same cycle enable is seen so the first rise lands at BCLK_HALF-1.
        if (state_q == S_RUN || enable) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                bclk_d    = ~bclk_q;
                rise      = ~bclk_q;
                fall      = bclk_q;
            end else begin
                div_cnt_d = div_cnt_q + DW'(1);
            end
        end
        wrap = fall && (bit_cnt_q == BIT_LAST);
        if (fall) bit_cnt_d = wrap ? '0 : bit_cnt_q + BW'(1);
        case (state_q)
            S_IDLE:  if (enable) state_d = S_RUN;
            default: if (wrap && !enable) state_d = S_IDLE;
        endcase
        lrck_d = (bit_cnt_d >= SLOT);
        fs_d   = wrap;
    end

    always_comb begin
        sync1_d  = aud_adcdat;
        sync2_d  = sync1_q;
        in_right = (bit_cnt_q >= SLOT);
        slot_pos = in_right ? bit_cnt_q - SLOT : bit_cnt_q;
        left_d   = left_q;
        right_d  = right_q;
        // Slot position 0 is the I2S one-bit delay after the LRCK edge.
        if (rise && slot_pos != '0 && slot_pos <= P_MAX) begin
            if (in_right) right_d = {right_q[SAMPLE_W-2:0], sync2_q};
            else          left_d  = {left_q[SAMPLE_W-2:0], sync2_q};
        end
        push_d = rise && (bit_cnt_q == PUSH_BIT);
    end

    always_comb begin
        head         = mem_q[rd_ptr_q];
        sample_valid = (level_q != '0);
        full         = (level_q == FULL_LVL);
        pop          = sample_valid && sample_ready;
        wr_en        = push_q && (!full || pop);
        drop         = push_q && full && !pop;
        wr_ptr_d     = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d      = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        mem_d = mem_q;
        if (wr_en) mem_d[wr_ptr_q] = {left_q, right_q};
        ovf_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            bclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
            fs_q      <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            push_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            bclk_q    <= bclk_d;
            lrck_q    <= lrck_d;
            fs_q      <= fs_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            left_q    <= left_d;
            right_q   <= right_d;
            push_q    <= push_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
        end
    end

    assign aud_bclk     = bclk_q;
    assign aud_adclrck  = lrck_q;
    assign frame_start  = fs_q;
    assign sample_left  = sample_valid ? head[2*SAMPLE_W-1:SAMPLE_W] : '0;
    assign sample_right = sample_valid ? head[SAMPLE_W-1:0] : '0;
    assign fifo_level   = level_q;
    assign overflow     = ovf_q;

endmodule
